// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: upstream controller for a 4-input display multiplexer.
// Captures a 4-digit word through a valid/ready handshake into a pending
// buffer and commits it to the display registers only at frame boundaries.
// It also generates the rotating digit select, the active-low anodes with
// optional leading-zero blanking, and a frame-done strobe.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   load_valid  load_data holds a word to capture
//   load_ready  pending buffer is free
//   load_data   digit 3 in [4W-1:3W] ... digit 0 in [W-1:0]
//   blank_lz    leading-zero blanking enable
//   d0..d3      registered display digits (mux data inputs)
//   s           digit select (mux select input)
//   an          active-low anodes, an[i] low only while s == i and digit i lit
//   frame_done  one-cycle pulse on the last cycle of each frame
module digit_scan_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [4*WIDTH-1:0] load_data,
    input  logic               blank_lz,
    output logic [WIDTH-1:0]   d0,
    output logic [WIDTH-1:0]   d1,
    output logic [WIDTH-1:0]   d2,
    output logic [WIDTH-1:0]   d3,
    output logic [1:0]         s,
    output logic [3:0]         an,
    output logic               frame_done
);

    localparam int unsigned PW = $clog2(DIV);

    typedef enum logic [0:0] {StBlank, StScan} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [1:0]              s_q, s_d;
    logic [4*WIDTH-1:0]      pend_q;
    logic                    pend_full_q;
    logic [3:0][WIDTH-1:0]   disp_q, disp_d;
    logic [3:0]              an_q, an_d;
    logic [3:0]              blank;

    logic tick;
    logic frame_end;
    logic accept;
    logic commit;

    assign tick      = (presc_q == PW'(DIV - 1));
    assign frame_end = tick && (s_q == 2'd3);
    // accept needs an empty buffer and commit needs a full one, so the two
    // never happen in the same cycle; a word offered on a committing edge
    // is taken one cycle later.
    assign accept    = load_valid && !pend_full_q;
    assign commit    = frame_end && pend_full_q;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        s_d     = tick ? s_q + 2'd1 : s_q;
        disp_d  = commit ? pend_q : disp_q;
        state_d = commit ? StScan : state_q;

        // Anodes are registered from next-state values so they stay in step
        // with s and the display digits rather than lagging a cycle.
        blank[3] = blank_lz && (disp_d[3] == '0);
        blank[2] = blank[3] && (disp_d[2] == '0);
        blank[1] = blank[2] && (disp_d[1] == '0);
        blank[0] = 1'b0;

        an_d = 4'b1111;
        if (state_d == StScan && !blank[s_d]) begin
            an_d[s_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBlank;
            presc_q     <= '0;
            s_q         <= 2'd0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            an_q        <= 4'b1111;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            s_q     <= s_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
            if (accept) begin
                pend_q      <= load_data;
                pend_full_q <= 1'b1;
            end else if (commit) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    assign load_ready = !pend_full_q;
    assign frame_done = frame_end;
    assign s          = s_q;
    assign an         = an_q;
    assign d0         = disp_q[0];
    assign d1         = disp_q[1];
    assign d2         = disp_q[2];
    assign d3         = disp_q[3];

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Upstream controller for the 4-input display multiplexer.
- Captures a 4-digit word through a valid/ready handshake into a pending buffer.
- Commits the pending word to four display registers only at frame boundaries, so a frame never mixes old and new digits.
- Generates the rotating 2-bit select, active-low digit anodes and a frame-done strobe; the display registers drive the mux data inputs and the select drives its select input.

Parameters:
- WIDTH, 4, bits per digit; must match the downstream mux width.
- DIV, 4, clock cycles each digit stays selected; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data holds a word to capture.
- load_ready  output  1  pending buffer is free; a word is accepted when load_valid && load_ready at a rising edge.
- load_data  input  4*WIDTH  digit 3 in [4W-1:3W], digit 0 in [W-1:0].
- blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
- d0, d1, d2, d3  output  WIDTH each  registered display digits, wired to the mux data inputs.
- s  output  2  digit select, wired to the mux select input.
- an  output  4  active-low anodes; an[i] is low only while s == i and digit i is lit.
- frame_done  output  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). All outputs and state are registered and update only on the rising edge of clk.
- Reset values: d0–d3 = 0, s = 0, prescaler = 0, pending buffer empty, load_ready = 1, an = 4'b1111, frame_done = 0, FSM = BLANK.
- Reset asserted mid-frame or mid-handshake discards the pending word and the displayed word, with no transfer.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick = (prescaler == DIV-1).
  - On tick, s <= s + 1 mod 4, so 3 wraps to 0.
  - The prescaler and s run in both FSM states.
- Frame end:
  - frame_end = tick && (s == 3).
  - frame_done is combinationally equal to frame_end.
  - One frame lasts 4*DIV cycles.
- Pending buffer:
  - load_ready = !pending_full.
  - On accept, pending <= load_data and pending_full <= 1.
- Commit:
  - At frame_end with pending_full = 1: d3..d0 <= pending and pending_full <= 0.
  - If load_valid is also high in that same cycle, load_ready is still 0, so the new word is not accepted. It becomes acceptable from the next cycle.
  - Commit latency: the word appears on d0–d3 the cycle after the first frame_end that follows acceptance. Worst case is 4*DIV cycles after acceptance.
- FSM:
  - BLANK: an = 4'b1111. Goes to SCAN on the first commit.
  - SCAN: an[i] = 0 iff s == i and digit i is not blanked; all other bits are 1. Leaves SCAN only on reset.
- Leading-zero blanking, active when blank_lz = 1:
  - Digit i ∈ {3,2,1} is blanked iff digit i and every higher digit equal 0.
  - Digit 0 is never blanked.
  - Example: a word of 0x0000 lights only digit 0.
- Back-pressure: while pending_full = 1, the producer must hold load_valid and load_data stable. The block never drops an accepted word.
- Digit ordering: s == 0 selects d0, the rightmost digit, with anode an[0].

Test Plan (DIV = 4, WIDTH = 4; frame = 16 cycles):
- Reset release, no load: for 40 cycles an == 4'b1111, d0–d3 == 0, load_ready == 1; s steps 0,1,2,3,0 every 4 cycles; frame_done pulses when s == 3 and prescaler == 3.
- Load 0x1234 at cycle 2 after reset: load_ready drops the next cycle. At the first frame_end (cycle 15) d3..d0 become 1,2,3,4 on the following edge and the FSM enters SCAN. After that, an cycles through 1110, 1101, 1011, 0111 in step with s = 0..3, and load_ready returns to 1.
- Back-pressure: load 0xAAAA, then hold load_valid with 0x5555 while pending is full. 0x5555 is accepted on the cycle after the first commit, and the display shows 0xAAAA for exactly one full frame before 0x5555.
- Leading-zero blanking: commit 0x0070 with blank_lz = 1. an[3] and an[2] stay 1 in every slot, while digits 1 and 0 light when selected. Then commit 0x0000: only an[0] ever goes low.
- Reset mid-frame with a pending word (0x9999 accepted, reset at s == 2): next cycle d0–d3 == 0, an == 4'b1111, load_ready == 1, s == 0. 0x9999 never appears on the outputs.
- Load presented on the frame_end cycle with pending full: the old pending word commits and the new word is accepted exactly one cycle later.
